// File: rtl/cpc_fifo_host_ctrl.sv
// CPC-side host controller for the CPC<->Pi HCT40105 FIFO link: Z80 I/O decode, FIFO strobes, status.
// Optional Z80 wait-state insertion on empty/full FIFOs is built when CPC_FIFO_WAIT_EN is defined.
module cpc_fifo_host_ctrl #(
    parameter logic [15:0] BASE_ADDR    = 16'hFD80,
    parameter int          SI_PULSE     = 2,
    parameter int          SO_PULSE     = 2,
    parameter int          RST_PULSE    = 4,
    parameter int          WAIT_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [15:0] A,
    input  logic        IOREQ_B,
    input  logic        RD_B,
    input  logic        WR_B,
    input  logic [7:0]  d_in,
    output logic [7:0]  d_out,
    output logic        d_oe,
    input  logic        fifo_host_dir,
    input  logic        fifo_host_dor,
    output logic        host_fifo_si,
    output logic        host_fifo_sob,
    output logic        host_fifo_oeb,
    output logic        host_fifo_reset,
    output logic        READY
);
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_SI   = 3'd1;
    localparam logic [2:0] ST_RD_HOLD = 3'd2;
    localparam logic [2:0] ST_RD_SOB  = 3'd3;
    localparam logic [2:0] ST_RST     = 3'd4;
`ifdef CPC_FIFO_WAIT_EN
    localparam logic [2:0] ST_WAIT_WR = 3'd5;
    localparam logic [2:0] ST_WAIT_RD = 3'd6;
    localparam int         WCNT_W     = $clog2(WAIT_TIMEOUT + 1);
    logic [WCNT_W-1:0]     wcnt_q, wcnt_d;
`else
    localparam int         unused_timeout = WAIT_TIMEOUT;
`endif

    logic [2:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       strb_q, strb_qq, acc_wr_q, acc_a0_q;
    logic [1:0] acc_cmd_q;
    logic       ovf_q, ovf_d, unf_q, unf_d, col_q, col_d;
    logic       hw_rst_q;
    logic       io_hit, strb, rd_data, rd_stat, start;
    logic       unused_bits;

    // A3:A2 are deliberately not decoded, so the ports alias across the 16-byte window.
    assign io_hit      = ~IOREQ_B & (A[15:4] == BASE_ADDR[15:4]) & ~A[1];
    assign strb        = io_hit & (~RD_B | ~WR_B);
    assign rd_data     = io_hit & ~RD_B & ~A[0];
    assign rd_stat     = io_hit & ~RD_B & A[0];
    assign start       = strb_q & ~strb_qq;
    assign unused_bits = ^{A[3:2], d_in[5:0]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        col_d   = col_q;
`ifdef CPC_FIFO_WAIT_EN
        wcnt_d  = wcnt_q;
`endif
        case (state_q)
            ST_WR_SI, ST_RD_SOB, ST_RST: begin
                if (cnt_q == 8'd0) state_d = ST_IDLE;
                else               cnt_d   = cnt_q - 8'd1;
            end
            ST_RD_HOLD: begin
                // FIFO1 output is held until the Z80 has latched it, then advanced.
                if (RD_B) begin
                    state_d = ST_RD_SOB;
                    cnt_d   = 8'(SO_PULSE - 1);
                end
            end
`ifdef CPC_FIFO_WAIT_EN
            ST_WAIT_WR: begin
                if (fifo_host_dir) begin
                    state_d = ST_WR_SI;
                    cnt_d   = 8'(SI_PULSE - 1);
                end else if (wcnt_q == WCNT_W'(WAIT_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    ovf_d   = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
            ST_WAIT_RD: begin
                if (fifo_host_dor) begin
                    state_d = ST_RD_HOLD;
                end else if (wcnt_q == WCNT_W'(WAIT_TIMEOUT - 1)) begin
                    state_d = ST_IDLE;
                    unf_d   = 1'b1;
                end else begin
                    wcnt_d  = wcnt_q + 1'b1;
                end
            end
`endif
            default: ;
        endcase

        if (start) begin
            if (state_q != ST_IDLE) begin
                col_d = 1'b1;
            end else if (!acc_a0_q) begin
                if (acc_wr_q) begin
                    if (fifo_host_dir) begin
                        state_d = ST_WR_SI;
                        cnt_d   = 8'(SI_PULSE - 1);
                    end else begin
`ifdef CPC_FIFO_WAIT_EN
                        state_d = ST_WAIT_WR;
                        wcnt_d  = '0;
`else
                        ovf_d   = 1'b1;
`endif
                    end
                end else begin
                    if (fifo_host_dor) begin
                        state_d = ST_RD_HOLD;
                    end else begin
`ifdef CPC_FIFO_WAIT_EN
                        state_d = ST_WAIT_RD;
                        wcnt_d  = '0;
`else
                        unf_d   = 1'b1;
`endif
                    end
                end
            end else if (acc_wr_q) begin
                if (acc_cmd_q[1]) begin
                    state_d = ST_RST;
                    cnt_d   = 8'(RST_PULSE - 1);
                end
                if (acc_cmd_q[0]) begin
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                    col_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            strb_q    <= 1'b0;
            strb_qq   <= 1'b0;
            acc_wr_q  <= 1'b0;
            acc_a0_q  <= 1'b0;
            acc_cmd_q <= 2'b00;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            col_q     <= 1'b0;
            hw_rst_q  <= 1'b1;
`ifdef CPC_FIFO_WAIT_EN
            wcnt_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            strb_q    <= strb;
            strb_qq   <= strb_q;
            acc_wr_q  <= ~WR_B;
            acc_a0_q  <= A[0];
            acc_cmd_q <= d_in[7:6];
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            col_q     <= col_d;
            hw_rst_q  <= 1'b0;
`ifdef CPC_FIFO_WAIT_EN
            wcnt_q    <= wcnt_d;
`endif
        end
    end

    assign host_fifo_si    = (state_q == ST_WR_SI);
    assign host_fifo_sob   = (state_q != ST_RD_SOB);
    assign host_fifo_reset = hw_rst_q | (state_q == ST_RST);
    assign host_fifo_oeb   = ~(rd_data & ~RESET);
    assign d_oe            = rd_stat & ~RESET;
    assign d_out           = d_oe ? {(state_q != ST_IDLE), 2'b00, col_q, unf_q, ovf_q,
                                     fifo_host_dor, fifo_host_dir} : 8'h00;
`ifdef CPC_FIFO_WAIT_EN
    assign READY = ~((state_q == ST_WAIT_WR) | (state_q == ST_WAIT_RD));
`else
    assign READY = 1'b1;
`endif
endmodule

// File: tb/tb_cpc_fifo_host_ctrl.sv
// Directed bench for cpc_fifo_host_ctrl: decode, FIFO strobes, status/flags, soft reset, collisions.
module tb_cpc_fifo_host_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic [15:0] A;
    logic        IOREQ_B, RD_B, WR_B;
    logic [7:0]  d_in, d_out;
    logic        d_oe, fifo_host_dir, fifo_host_dor;
    logic        host_fifo_si, host_fifo_sob, host_fifo_oeb, host_fifo_reset, READY;

    int checks = 0;
    int failures = 0;

    cpc_fifo_host_ctrl dut (
        .CLK(CLK), .RESET(RESET), .A(A), .IOREQ_B(IOREQ_B), .RD_B(RD_B), .WR_B(WR_B),
        .d_in(d_in), .d_out(d_out), .d_oe(d_oe),
        .fifo_host_dir(fifo_host_dir), .fifo_host_dor(fifo_host_dor),
        .host_fifo_si(host_fifo_si), .host_fifo_sob(host_fifo_sob),
        .host_fifo_oeb(host_fifo_oeb), .host_fifo_reset(host_fifo_reset), .READY(READY)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic bus_idle();
        IOREQ_B = 1'b1;
        RD_B    = 1'b1;
        WR_B    = 1'b1;
    endtask

    task automatic bus_drive(input logic [15:0] addr, input logic wr, input logic [7:0] data);
        A       = addr;
        d_in    = data;
        IOREQ_B = 1'b0;
        RD_B    = wr;
        WR_B    = ~wr;
    endtask

    task automatic read_status(output logic [7:0] v, output logic oe);
        bus_drive(16'hFD81, 1'b0, 8'h00);
        #1;
        v  = d_out;
        oe = d_oe;
        tick(); tick();
        bus_idle();
        tick(); tick();
    endtask

    task automatic write_trace(input logic [15:0] addr, input logic [7:0] data,
                               output logic [5:0] si_tr, output logic [5:0] rst_tr);
        bus_drive(addr, 1'b1, data);
        for (int i = 0; i < 6; i++) begin
            tick();
            si_tr[i]  = host_fifo_si;
            rst_tr[i] = host_fifo_reset;
            if (i == 2) bus_idle();
        end
        tick();
    endtask

    task automatic test_reset();
        logic [7:0] v; logic oe;
        bus_idle(); A = 16'h0000; d_in = 8'h00;
        fifo_host_dir = 1'b1; fifo_host_dor = 1'b1;
        RESET = 1'b1;
        tick(); tick();
        checks++;
        if ({host_fifo_si, host_fifo_sob, host_fifo_oeb, d_oe, READY, host_fifo_reset} !== 6'b011011) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 011011",
                     {host_fifo_si, host_fifo_sob, host_fifo_oeb, d_oe, READY, host_fifo_reset});
        end
        checks++;
        if (d_out !== 8'h00) begin failures++; $display("FAIL reset_dout: got %h expected 00", d_out); end
        RESET = 1'b0;
        tick();
        checks++;
        if (host_fifo_reset !== 1'b0) begin failures++; $display("FAIL reset_release: got %b expected 0", host_fifo_reset); end
        read_status(v, oe);
        checks++;
        if ({oe, v} !== 9'h103) begin failures++; $display("FAIL reset_status: got oe=%b %h expected oe=1 03", oe, v); end
    endtask

    task automatic test_write();
        logic [5:0] si_tr, rst_tr; logic [7:0] v; logic oe;
        fifo_host_dir = 1'b1; fifo_host_dor = 1'b1;
        write_trace(16'hFD80, 8'h55, si_tr, rst_tr);
        checks++;
        if (si_tr !== 6'b000110) begin failures++; $display("FAIL write_si_pulse: got %b expected 000110", si_tr); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL write_status: got %h expected 03", v); end
        fifo_host_dir = 1'b0; fifo_host_dor = 1'b0;
        write_trace(16'hFD80, 8'hAA, si_tr, rst_tr);
        checks++;
        if (si_tr !== 6'b000000) begin failures++; $display("FAIL write_full_si: got %b expected 000000", si_tr); end
        checks++;
        if (READY !== 1'b1) begin failures++; $display("FAIL write_full_ready: got %b expected 1", READY); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h04) begin failures++; $display("FAIL write_full_ovf: got %h expected 04", v); end
    endtask

    task automatic test_read();
        logic [3:0] tr; logic [7:0] v; logic oe;
        fifo_host_dir = 1'b1; fifo_host_dor = 1'b1;
        bus_drive(16'hFD80, 1'b0, 8'h00);
        #1;
        checks++;
        if (host_fifo_oeb !== 1'b0) begin failures++; $display("FAIL read_oeb_low: got %b expected 0", host_fifo_oeb); end
        tick(); tick();
        checks++;
        if ({host_fifo_sob, host_fifo_oeb} !== 2'b10) begin
            failures++; $display("FAIL read_hold: got sob/oeb=%b expected 10", {host_fifo_sob, host_fifo_oeb});
        end
        bus_idle();
        #1;
        checks++;
        if (host_fifo_oeb !== 1'b1) begin failures++; $display("FAIL read_oeb_release: got %b expected 1", host_fifo_oeb); end
        for (int i = 0; i < 4; i++) begin tick(); tr[i] = host_fifo_sob; end
        checks++;
        if (tr !== 4'b1100) begin failures++; $display("FAIL read_sob_pulse: got %b expected 1100", tr); end
        tick();
        fifo_host_dor = 1'b0;
        bus_drive(16'hFD80, 1'b0, 8'h00);
        #1;
        checks++;
        if (host_fifo_oeb !== 1'b0) begin failures++; $display("FAIL read_empty_oeb: got %b expected 0", host_fifo_oeb); end
        tick(); tick();
        bus_idle();
        for (int i = 0; i < 4; i++) begin tick(); tr[i] = host_fifo_sob; end
        checks++;
        if (tr !== 4'b1111) begin failures++; $display("FAIL read_empty_sob: got %b expected 1111", tr); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h0D) begin failures++; $display("FAIL read_unf_status: got %h expected 0D", v); end
    endtask

    task automatic test_soft_reset();
        logic [5:0] tr, si_tr; logic [7:0] v, vmid; logic oe, oemid;
        fifo_host_dir = 1'b1; fifo_host_dor = 1'b1;
        bus_drive(16'hFD81, 1'b1, 8'h80);
        tick(); tr[0] = host_fifo_reset;
        tick(); tr[1] = host_fifo_reset;
        bus_idle();
        tick(); tr[2] = host_fifo_reset;
        bus_drive(16'hFD81, 1'b0, 8'h00);
        #1;
        vmid = d_out; oemid = d_oe;
        tick(); tr[3] = host_fifo_reset;
        bus_idle();
        tick(); tr[4] = host_fifo_reset;
        tick(); tr[5] = host_fifo_reset;
        tick(); tick();
        checks++;
        if (tr !== 6'b011110) begin failures++; $display("FAIL swrst_pulse: got %b expected 011110", tr); end
        checks++;
        if ({oemid, vmid} !== 9'h18F) begin failures++; $display("FAIL swrst_busy_status: got oe=%b %h expected oe=1 8F", oemid, vmid); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h1F) begin failures++; $display("FAIL swrst_col_flag: got %h expected 1F", v); end
        write_trace(16'hFD81, 8'h40, si_tr, tr);
        checks++;
        if (tr !== 6'b000000) begin failures++; $display("FAIL clear_no_reset: got %b expected 000000", tr); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL clear_flags: got %h expected 03", v); end
    endtask

    task automatic test_collision();
        logic [5:0] tr, rst_tr; logic [7:0] v; logic oe;
        fifo_host_dir = 1'b1; fifo_host_dor = 1'b1;
        bus_drive(16'hFD80, 1'b1, 8'h11);
        tick(); tr[0] = host_fifo_si;
        bus_idle();
        tick(); tr[1] = host_fifo_si;
        bus_drive(16'hFD80, 1'b1, 8'h22);
        tick(); tr[2] = host_fifo_si;
        bus_idle();
        tick(); tr[3] = host_fifo_si;
        tick(); tr[4] = host_fifo_si;
        tick(); tr[5] = host_fifo_si;
        tick();
        checks++;
        if (tr !== 6'b000110) begin failures++; $display("FAIL col_si_trace: got %b expected 000110", tr); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h13) begin failures++; $display("FAIL col_flag: got %h expected 13", v); end
        write_trace(16'hFD81, 8'hC0, tr, rst_tr);
        checks++;
        if (rst_tr !== 6'b011110) begin failures++; $display("FAIL reset_and_clear_pulse: got %b expected 011110", rst_tr); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL reset_and_clear_flags: got %h expected 03", v); end
        bus_drive(16'hFD80, 1'b1, 8'h33);
        tick(); tick();
        checks++;
        if (host_fifo_si !== 1'b1) begin failures++; $display("FAIL midsi_active: got %b expected 1", host_fifo_si); end
        bus_idle();
        RESET = 1'b1;
        tick();
        checks++;
        if ({host_fifo_si, host_fifo_sob, host_fifo_oeb, d_oe, READY, host_fifo_reset} !== 6'b011011) begin
            failures++;
            $display("FAIL midsi_reset: got %b expected 011011",
                     {host_fifo_si, host_fifo_sob, host_fifo_oeb, d_oe, READY, host_fifo_reset});
        end
        RESET = 1'b0;
        tick(); tick();
        read_status(v, oe);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL midsi_reset_status: got %h expected 03", v); end
    endtask

    task automatic test_decode();
        logic [5:0] si_tr, rst_tr; logic [3:0] tr; logic [7:0] v; logic oe;
        fifo_host_dir = 1'b1; fifo_host_dor = 1'b1;
        write_trace(16'hFD8C, 8'h01, si_tr, rst_tr);
        checks++;
        if (si_tr !== 6'b000110) begin failures++; $display("FAIL decode_alias: got %b expected 000110", si_tr); end
        write_trace(16'hFD82, 8'h02, si_tr, rst_tr);
        checks++;
        if (si_tr !== 6'b000000) begin failures++; $display("FAIL decode_a1: got %b expected 000000", si_tr); end
        write_trace(16'hFE80, 8'h03, si_tr, rst_tr);
        checks++;
        if (si_tr !== 6'b000000) begin failures++; $display("FAIL decode_base: got %b expected 000000", si_tr); end
        A = 16'hFD80; IOREQ_B = 1'b0; RD_B = 1'b1; WR_B = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tr[i] = host_fifo_sob & host_fifo_oeb & ~host_fifo_si;
        end
        bus_idle();
        tick(); tick();
        checks++;
        if (tr !== 4'b1111) begin failures++; $display("FAIL decode_intack: got %b expected 1111", tr); end
        read_status(v, oe);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL decode_status: got %h expected 03", v); end
    endtask

`ifdef CPC_FIFO_WAIT_EN
    task automatic test_wait();
        int low; logic done, si_now, si_any; logic [7:0] v; logic oe;
        fifo_host_dir = 1'b0; fifo_host_dor = 1'b1;
        low = 0; done = 1'b0; si_now = 1'b0;
        bus_drive(16'hFD80, 1'b1, 8'h44);
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (!READY) begin
                low++;
                if (low == 10) fifo_host_dir = 1'b1;
            end else if (low > 0) begin
                done = 1'b1;
                si_now = host_fifo_si;
            end
        end
        bus_idle();
        tick(); tick(); tick(); tick();
        checks++;
        if ({done, si_now, low} !== {1'b1, 1'b1, 32'd10}) begin
            failures++; $display("FAIL wait_release: got done=%b si=%b low=%0d expected 1 1 10", done, si_now, low);
        end
        read_status(v, oe);
        checks++;
        if (v !== 8'h03) begin failures++; $display("FAIL wait_no_ovf: got %h expected 03", v); end
        fifo_host_dir = 1'b0;
        low = 0; done = 1'b0; si_any = 1'b0;
        bus_drive(16'hFD80, 1'b1, 8'h45);
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            si_any |= host_fifo_si;
            if (!READY) low++;
            else if (low > 0) done = 1'b1;
        end
        bus_idle();
        tick(); tick();
        checks++;
        if ({done, si_any, low} !== {1'b1, 1'b0, 32'd255}) begin
            failures++; $display("FAIL wait_timeout: got done=%b si=%b low=%0d expected 1 0 255", done, si_any, low);
        end
        read_status(v, oe);
        checks++;
        if (v !== 8'h06) begin failures++; $display("FAIL wait_timeout_ovf: got %h expected 06", v); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_soft_reset();
        test_collision();
        test_decode();
`ifdef CPC_FIFO_WAIT_EN
        test_wait();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
